regfile_nbit: RTL and testbench
===============================

// Module: regfile_nbit
// PURPOSE
//  Parametrised CPU register file: DEPTH entries of WIDTH bits, two read ports, one write port.
//  Per-byte write enables and an optional hard-wired zero entry 0.
//  Per-entry pending scoreboard: decode reserves a destination, writeback releases it.
//  Sits between decode (reads, reserve) and writeback (write); replaces the fixed 32-bit register banks.
// PARAMETERS
//  WIDTH      32  data width in bits; multiple of 8
//  DEPTH      32  number of entries; power of two, >= 2
//  ZERO_REG   1   1: entry 0 reads 0, ignores writes and reserves; 0: entry 0 is ordinary
//  READ_REG   0   0: combinational read; 1: read data registered (1-cycle latency)
// PORTS
//  clock             in   1              rising-edge clock
//  ctrl_reset_n      in   1              synchronous active-low reset
//  ctrl_writeEnable  in   1              write strobe
//  ctrl_writeReg     in   log2(DEPTH)    write address
//  ctrl_byteEnable   in   WIDTH/8        byte lanes written when ctrl_writeEnable=1
//  data_writeReg     in   WIDTH          write data
//  ctrl_readRegA     in   log2(DEPTH)    read address, port A
//  ctrl_readRegB     in   log2(DEPTH)    read address, port B
//  data_readRegA     out  WIDTH          read data, port A
//  data_readRegB     out  WIDTH          read data, port B
//  ctrl_reserve      in   1              mark ctrl_reserveReg pending
//  ctrl_reserveReg   in   log2(DEPTH)    entry to reserve
//  pending_A         out  1              entry at ctrl_readRegA is pending
//  pending_B         out  1              entry at ctrl_readRegB is pending
//  pending_any       out  1              OR of all pending bits
// BEHAVIOUR
//  Reset: on a rising edge with ctrl_reset_n=0, all entries, all pending bits and the READ_REG output registers clear to 0.
//   Reset overrides write and reserve in the same cycle.
//  Write: on a rising edge with ctrl_writeEnable=1, byte lane k of the entry updates iff ctrl_byteEnable[k]=1. Other lanes hold.
//  Write with ctrl_byteEnable=0 changes no data but still clears the pending bit.
//  Pending: write to entry n clears pend[n]; ctrl_reserve sets pend[ctrl_reserveReg].
//   Same entry, same cycle, both write and reserve: reserve wins and pend ends at 1 (new producer issued).
//   Reserving an already pending entry leaves it at 1; no error.
//  Read, READ_REG=0: data_readRegX = entry[ctrl_readRegX] combinationally (pre-edge value unless bypass is enabled).
//  Read, READ_REG=1: data sampled each edge; output shows the entry as it stands after that edge's write. Latency 1.
//  pending_A/B: always combinational on the current pend vector; not delayed by READ_REG.
//  ZERO_REG=1: entry 0 reads 0; write/reserve to it is a no-op; pend[0] is always 0.
//  Both read ports may address the same entry; both return identical data.
// CONFIGURATION
//  REGFILE_BYPASS_EN defined: with READ_REG=0, a read of the entry being written this cycle returns the merged value.
//   Merged value = new bytes where enabled, old bytes elsewhere. pending_A/B for that entry reads 0 unless it is reserved in the same cycle.
//   The merged value is zero for entry 0 when ZERO_REG=1.
//  Not defined: reads always return stored (pre-edge) contents and pending reflects stored bits; write-to-read forwarding is left to the pipeline.
//  No effect when READ_REG=1: that path already returns post-write data.
// STRUCTURE
//  Package regfile_pkg: ADDR_W = $clog2(DEPTH) helper function, BYTE_W = 8 constant, default WIDTH/DEPTH localparams.
//  Sub-module reg_nbit (WIDTH, BYTES): one entry. Per-byte enabled DFFs with synchronous active-low clear. Instantiated DEPTH times in a generate loop.
//  Top level holds the write decoder, read muxes, pending vector, the optional bypass mux and the optional output registers.
// TESTING
//  1. Reset, then write entry 5 = 0xDEADBEEF with byteEnable=0xF; read A=5 next cycle -> 0xDEADBEEF; pending_any=0.
//  2. Entry 5 = 0xDEADBEEF; write 0x11223344 with byteEnable=0x5 -> entry 5 = 0xDE22BE44.
//  3. ZERO_REG=1: write 0 = 0xFFFFFFFF and reserve 0 -> read A=0 gives 0; pending_A=0, pending_any=0.
//  4. Reserve 7 -> pending_A=1 (A=7); same cycle write 7 and reserve 7 -> pending stays 1; write 7 alone -> pending 0.
//  5. BYPASS_EN, READ_REG=0: entry 3 = 0x0; write 3 = 0xCAFEF00D, read A=3, read B=3 in the same cycle -> both 0xCAFEF00D. Without the macro both read 0x0.
//  6. Write 9 = 0x1234 and pull ctrl_reset_n low in the same cycle -> entry 9 = 0 and all pending bits 0 afterwards.
//  READ_REG=1: repeat scenario 1 and check data appears exactly one edge after the address is presented.

Source files
------------

// File: rtl/regfile_nbit_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
//  Shared constants and helpers for the parametrised register file.
//  BYTE_W    : width of one write-enable lane
//  DEF_WIDTH : default entry width
//  DEF_DEPTH : default entry count
//  addr_w()  : address width for a given depth (at least 1 bit)
// -----------------------------------------------------------------------------
package regfile_pkg;

   localparam int BYTE_W    = 8;
   localparam int DEF_WIDTH = 32;
   localparam int DEF_DEPTH = 32;

   function automatic int addr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/regfile_nbit_reg.sv
// -----------------------------------------------------------------------------
// reg_nbit
//  One register-file entry: WIDTH bits split into BYTES byte lanes, each lane
//  loaded independently, whole entry cleared by a synchronous active-low reset.
// Ports
//  clock      in  1      rising-edge clock
//  i_reset_n  in  1      synchronous active-low clear
//  i_byte_we  in  BYTES  per-lane load enable
//  i_data     in  WIDTH  load data
//  o_q        out WIDTH  stored value
// -----------------------------------------------------------------------------
module reg_nbit
   import regfile_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int BYTES = WIDTH / BYTE_W
)(
   input  logic             clock,
   input  logic             i_reset_n,
   input  logic [BYTES-1:0] i_byte_we,
   input  logic [WIDTH-1:0] i_data,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] r_q;

   always_ff @(posedge clock) begin
      if (!i_reset_n) begin
         r_q <= '0;
      end else begin
         for (int k = 0; k < BYTES; k++) begin
            if (i_byte_we[k]) r_q[k*BYTE_W +: BYTE_W] <= i_data[k*BYTE_W +: BYTE_W];
         end
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/regfile_nbit.sv
// -----------------------------------------------------------------------------
// regfile_nbit
//  Parametrised CPU register file: DEPTH x WIDTH, two read ports, one write
//  port with byte enables, optional hard-wired zero entry 0, and a per-entry
//  pending scoreboard (decode reserves a destination, writeback releases it).
//  Optional feature macro: REGFILE_BYPASS_EN -- with READ_REG=0, a read of the
//  entry written this cycle returns the merged (post-write) value and its
//  pending bit reads 0 unless the entry is also reserved this cycle.
// Ports
//  clock, ctrl_reset_n                        clock / sync active-low reset
//  ctrl_writeEnable, ctrl_writeReg,
//  ctrl_byteEnable, data_writeReg             write port
//  ctrl_readRegA/B -> data_readRegA/B         read ports
//  ctrl_reserve, ctrl_reserveReg              scoreboard reserve
//  pending_A/B, pending_any                   scoreboard status
// -----------------------------------------------------------------------------
module regfile_nbit
   import regfile_pkg::*;
#(
   parameter  int WIDTH    = DEF_WIDTH,
   parameter  int DEPTH    = DEF_DEPTH,
   parameter  int ZERO_REG = 1,
   parameter  int READ_REG = 0,
   localparam int ADDR_W   = addr_w(DEPTH),
   localparam int BYTES    = WIDTH / BYTE_W
)(
   input  logic              clock,
   input  logic              ctrl_reset_n,
   input  logic              ctrl_writeEnable,
   input  logic [ADDR_W-1:0] ctrl_writeReg,
   input  logic [BYTES-1:0]  ctrl_byteEnable,
   input  logic [WIDTH-1:0]  data_writeReg,
   input  logic [ADDR_W-1:0] ctrl_readRegA,
   input  logic [ADDR_W-1:0] ctrl_readRegB,
   output logic [WIDTH-1:0]  data_readRegA,
   output logic [WIDTH-1:0]  data_readRegB,
   input  logic              ctrl_reserve,
   input  logic [ADDR_W-1:0] ctrl_reserveReg,
   output logic              pending_A,
   output logic              pending_B,
   output logic              pending_any
);

`ifdef REGFILE_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif
   // Registered reads always need the post-write value; combinational reads
   // only when bypass is built in.
   localparam bit FWD_EN = BYPASS || (READ_REG != 0);

   logic [WIDTH-1:0] w_entry [DEPTH];
   logic [DEPTH-1:0] r_pend;
   logic [WIDTH-1:0] w_merged;
   logic [WIDTH-1:0] w_fwdA, w_fwdB;
   logic             w_hitA, w_hitB;
   logic             w_clrA, w_clrB;

   // Storage and write decode
   for (genvar g = 0; g < DEPTH; g++) begin : g_entry
      if (ZERO_REG != 0 && g == 0) begin : g_zero
         assign w_entry[g] = '0;
      end else begin : g_reg
         logic             w_sel;
         logic [BYTES-1:0] w_lane_we;
         assign w_sel     = ctrl_writeEnable && (ctrl_writeReg == ADDR_W'(g));
         assign w_lane_we = w_sel ? ctrl_byteEnable : '0;
         reg_nbit #(.WIDTH(WIDTH), .BYTES(BYTES)) u_reg (
            .clock     (clock),
            .i_reset_n (ctrl_reset_n),
            .i_byte_we (w_lane_we),
            .i_data    (data_writeReg),
            .o_q       (w_entry[g])
         );
      end
   end

   // Pending scoreboard: reserve takes priority over the releasing write.
   always_ff @(posedge clock) begin
      if (!ctrl_reset_n) begin
         r_pend <= '0;
      end else begin
         for (int n = 0; n < DEPTH; n++) begin
            if (ZERO_REG != 0 && n == 0)
               r_pend[n] <= 1'b0;
            else if (ctrl_reserve && ctrl_reserveReg == ADDR_W'(n))
               r_pend[n] <= 1'b1;
            else if (ctrl_writeEnable && ctrl_writeReg == ADDR_W'(n))
               r_pend[n] <= 1'b0;
         end
      end
   end

   // Post-write value of the entry being written (zero entry stays zero).
   always_comb begin
      w_merged = w_entry[ctrl_writeReg];
      for (int k = 0; k < BYTES; k++) begin
         if (ctrl_byteEnable[k]) w_merged[k*BYTE_W +: BYTE_W] = data_writeReg[k*BYTE_W +: BYTE_W];
      end
      if (ZERO_REG != 0 && ctrl_writeReg == '0) w_merged = '0;
   end

   assign w_hitA = FWD_EN && ctrl_writeEnable && (ctrl_writeReg == ctrl_readRegA);
   assign w_hitB = FWD_EN && ctrl_writeEnable && (ctrl_writeReg == ctrl_readRegB);
   assign w_fwdA = w_hitA ? w_merged : w_entry[ctrl_readRegA];
   assign w_fwdB = w_hitB ? w_merged : w_entry[ctrl_readRegB];

   // A bypassed write releases the entry early unless it is re-reserved now.
   assign w_clrA = BYPASS && (READ_REG == 0) && w_hitA &&
                   !(ctrl_reserve && ctrl_reserveReg == ctrl_readRegA);
   assign w_clrB = BYPASS && (READ_REG == 0) && w_hitB &&
                   !(ctrl_reserve && ctrl_reserveReg == ctrl_readRegB);

   assign pending_A   = r_pend[ctrl_readRegA] && !w_clrA;
   assign pending_B   = r_pend[ctrl_readRegB] && !w_clrB;
   assign pending_any = |r_pend;

   // Read data path
   if (READ_REG != 0) begin : g_rreg
      logic [WIDTH-1:0] r_rdA, r_rdB;
      always_ff @(posedge clock) begin
         if (!ctrl_reset_n) begin
            r_rdA <= '0;
            r_rdB <= '0;
         end else begin
            r_rdA <= w_fwdA;
            r_rdB <= w_fwdB;
         end
      end
      assign data_readRegA = r_rdA;
      assign data_readRegB = r_rdB;
   end else begin : g_comb
      assign data_readRegA = w_fwdA;
      assign data_readRegB = w_fwdB;
   end

endmodule

// File: tb/tb_regfile_nbit.sv
// -----------------------------------------------------------------------------
// tb_regfile_nbit
//  Self-checking bench for regfile_nbit (WIDTH=32, DEPTH=32, ZERO_REG=1).
//  One instance with combinational reads, one with registered reads, both fed
//  by the same stimulus and compared against an array-based reference model.
// -----------------------------------------------------------------------------
module tb_regfile_nbit;

   logic        clock = 1'b0;
   logic        ctrl_reset_n;
   logic        ctrl_writeEnable;
   logic [4:0]  ctrl_writeReg;
   logic [3:0]  ctrl_byteEnable;
   logic [31:0] data_writeReg;
   logic [4:0]  ctrl_readRegA, ctrl_readRegB;
   logic        ctrl_reserve;
   logic [4:0]  ctrl_reserveReg;

   logic [31:0] rdA, rdB, rrA, rrB;
   logic        pA, pB, pAny, rpA, rpB, rpAny;

   int n_checks = 0;
   int n_fail   = 0;

   // reference model state
   logic [31:0] m_mem [32];
   bit          m_pend [32];
   logic [31:0] exp_rrA, exp_rrB;

`ifdef REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   always #5 clock = ~clock;

   regfile_nbit #(.WIDTH(32), .DEPTH(32), .ZERO_REG(1), .READ_REG(0)) dut (
      .clock(clock), .ctrl_reset_n(ctrl_reset_n),
      .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg),
      .ctrl_byteEnable(ctrl_byteEnable), .data_writeReg(data_writeReg),
      .ctrl_readRegA(ctrl_readRegA), .ctrl_readRegB(ctrl_readRegB),
      .data_readRegA(rdA), .data_readRegB(rdB),
      .ctrl_reserve(ctrl_reserve), .ctrl_reserveReg(ctrl_reserveReg),
      .pending_A(pA), .pending_B(pB), .pending_any(pAny));

   regfile_nbit #(.WIDTH(32), .DEPTH(32), .ZERO_REG(1), .READ_REG(1)) dut_rr (
      .clock(clock), .ctrl_reset_n(ctrl_reset_n),
      .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg),
      .ctrl_byteEnable(ctrl_byteEnable), .data_writeReg(data_writeReg),
      .ctrl_readRegA(ctrl_readRegA), .ctrl_readRegB(ctrl_readRegB),
      .data_readRegA(rrA), .data_readRegB(rrB),
      .ctrl_reserve(ctrl_reserve), .ctrl_reserveReg(ctrl_reserveReg),
      .pending_A(rpA), .pending_B(rpB), .pending_any(rpAny));

   // ---------------- reference model ----------------
   function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] d,
                                         input logic [3:0] be);
      logic [31:0] v = old_v;
      for (int k = 0; k < 4; k++) if (be[k]) v[k*8 +: 8] = d[k*8 +: 8];
      return v;
   endfunction

   function automatic logic [31:0] exp_rd(input logic [4:0] a);
      logic [31:0] v = m_mem[a];
      if (BYP && ctrl_writeEnable && ctrl_writeReg == a)
         v = (a == 0) ? 32'h0 : merge(m_mem[a], data_writeReg, ctrl_byteEnable);
      return v;
   endfunction

   function automatic bit exp_pend(input logic [4:0] a);
      bit p = m_pend[a];
      if (BYP && ctrl_writeEnable && ctrl_writeReg == a && !(ctrl_reserve && ctrl_reserveReg == a))
         p = 1'b0;
      return p;
   endfunction

   function automatic bit exp_any();
      bit r = 1'b0;
      for (int n = 0; n < 32; n++) r |= m_pend[n];
      return r;
   endfunction

   task automatic model_edge();
      if (!ctrl_reset_n) begin
         for (int n = 0; n < 32; n++) begin m_mem[n] = '0; m_pend[n] = 1'b0; end
      end else begin
         if (ctrl_writeEnable) begin
            m_mem[ctrl_writeReg]  = merge(m_mem[ctrl_writeReg], data_writeReg, ctrl_byteEnable);
            m_pend[ctrl_writeReg] = 1'b0;
         end
         if (ctrl_reserve) m_pend[ctrl_reserveReg] = 1'b1;
         m_mem[0]  = '0;
         m_pend[0] = 1'b0;
      end
   endtask

   // advance one edge; inputs change 1 time unit after the edge
   task automatic tick();
      @(posedge clock);
      model_edge();
      exp_rrA = m_mem[ctrl_readRegA];
      exp_rrB = m_mem[ctrl_readRegB];
      #1;
   endtask

   task automatic idle();
      ctrl_writeEnable = 0; ctrl_reserve = 0; ctrl_byteEnable = 0;
      data_writeReg = 0; ctrl_writeReg = 0; ctrl_reserveReg = 0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      ctrl_reset_n = 0; ctrl_readRegA = 0; ctrl_readRegB = 0; idle();
      tick(); tick();
      ctrl_reset_n = 1;
      for (int a = 1; a < 32; a += 6) begin
         ctrl_readRegA = 5'(a); ctrl_readRegB = 5'(31 - a); #1;
         n_checks++; if (rdA !== 32'h0) begin n_fail++; $display("FAIL reset_rdA a=%0d got %h want 0", a, rdA); end
         n_checks++; if (rdB !== 32'h0) begin n_fail++; $display("FAIL reset_rdB a=%0d got %h want 0", a, rdB); end
      end
      n_checks++; if (pAny !== 1'b0 || rpAny !== 1'b0) begin n_fail++; $display("FAIL reset_pend_any got %b/%b want 0", pAny, rpAny); end
      n_checks++; if (rrA !== 32'h0) begin n_fail++; $display("FAIL reset_rrA got %h want 0", rrA); end
   endtask

   task automatic test_full_write();
      ctrl_writeEnable = 1; ctrl_writeReg = 5; ctrl_byteEnable = 4'hF;
      data_writeReg = 32'hDEADBEEF; ctrl_readRegA = 5; #1;
      n_checks++; if (rrA !== exp_rrA) begin n_fail++; $display("FAIL rr_latency_pre got %h want %h", rrA, exp_rrA); end
      tick(); idle(); #1;
      n_checks++; if (rrA !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rr_latency_post got %h want deadbeef", rrA); end
      n_checks++; if (rdA !== 32'hDEADBEEF) begin n_fail++; $display("FAIL full_write got %h want deadbeef", rdA); end
      n_checks++; if (pAny !== 1'b0) begin n_fail++; $display("FAIL full_write_pend_any got %b want 0", pAny); end
   endtask

   task automatic test_byte_enable();
      ctrl_writeEnable = 1; ctrl_writeReg = 5; ctrl_byteEnable = 4'h5;
      data_writeReg = 32'h11223344; ctrl_readRegA = 5;
      tick(); idle(); #1;
      n_checks++; if (rdA !== 32'hDE22BE44) begin n_fail++; $display("FAIL byte_enable got %h want de22be44", rdA); end
      n_checks++; if (rrA !== 32'hDE22BE44) begin n_fail++; $display("FAIL byte_enable_rr got %h want de22be44", rrA); end
   endtask

   task automatic test_zero_reg();
      ctrl_writeEnable = 1; ctrl_writeReg = 0; ctrl_byteEnable = 4'hF; data_writeReg = 32'hFFFFFFFF;
      ctrl_reserve = 1; ctrl_reserveReg = 0; ctrl_readRegA = 0;
      tick(); idle(); #1;
      n_checks++; if (rdA !== 32'h0) begin n_fail++; $display("FAIL zero_reg_data got %h want 0", rdA); end
      n_checks++; if (pA !== 1'b0 || pAny !== 1'b0) begin n_fail++; $display("FAIL zero_reg_pend got %b/%b want 0/0", pA, pAny); end
   endtask

   task automatic test_pending();
      ctrl_reserve = 1; ctrl_reserveReg = 7; ctrl_readRegA = 7; ctrl_readRegB = 5;
      tick(); idle(); #1;
      n_checks++; if (pA !== 1'b1 || pB !== 1'b0) begin n_fail++; $display("FAIL pend_reserve got %b/%b want 1/0", pA, pB); end
      n_checks++; if (rpA !== 1'b1) begin n_fail++; $display("FAIL pend_reserve_rr got %b want 1", rpA); end
      ctrl_writeEnable = 1; ctrl_writeReg = 7; ctrl_byteEnable = 4'hF; data_writeReg = 32'h77;
      ctrl_reserve = 1; ctrl_reserveReg = 7; #1;
      n_checks++; if (pA !== 1'b1) begin n_fail++; $display("FAIL pend_wr_res_same got %b want 1", pA); end
      tick(); idle(); #1;
      n_checks++; if (pA !== 1'b1) begin n_fail++; $display("FAIL pend_reserve_wins got %b want 1", pA); end
      ctrl_writeEnable = 1; ctrl_writeReg = 7; ctrl_byteEnable = 4'h0; data_writeReg = 32'hFFFF; #1;
      n_checks++; if (pA !== exp_pend(7)) begin n_fail++; $display("FAIL pend_bypass got %b want %b", pA, exp_pend(7)); end
      n_checks++; if (rpA !== 1'b1) begin n_fail++; $display("FAIL pend_rr_not_bypassed got %b want 1", rpA); end
      tick(); idle(); #1;
      n_checks++; if (pA !== 1'b0 || pAny !== 1'b0) begin n_fail++; $display("FAIL pend_release got %b/%b want 0/0", pA, pAny); end
      n_checks++; if (rdA !== 32'h77) begin n_fail++; $display("FAIL be0_holds got %h want 77", rdA); end
   endtask

   task automatic test_bypass();
      logic [31:0] want;
      want = BYP ? 32'hCAFEF00D : 32'h0;
      ctrl_writeEnable = 1; ctrl_writeReg = 3; ctrl_byteEnable = 4'hF; data_writeReg = 32'h0;
      tick();
      data_writeReg = 32'hCAFEF00D; ctrl_readRegA = 3; ctrl_readRegB = 3; #1;
      n_checks++; if (rdA !== want) begin n_fail++; $display("FAIL bypass_A got %h want %h", rdA, want); end
      n_checks++; if (rdB !== want) begin n_fail++; $display("FAIL bypass_B got %h want %h", rdB, want); end
      tick(); idle(); #1;
      n_checks++; if (rdA !== 32'hCAFEF00D || rdB !== 32'hCAFEF00D) begin n_fail++; $display("FAIL bypass_after got %h/%h want cafef00d", rdA, rdB); end
   endtask

   task automatic test_reset_overrides();
      ctrl_reserve = 1; ctrl_reserveReg = 12; tick(); idle();
      ctrl_reset_n = 0; ctrl_writeEnable = 1; ctrl_writeReg = 9; ctrl_byteEnable = 4'hF;
      data_writeReg = 32'h1234; ctrl_reserve = 1; ctrl_reserveReg = 9;
      tick(); idle(); ctrl_reset_n = 1; ctrl_readRegA = 9; ctrl_readRegB = 12; #1;
      n_checks++; if (rdA !== 32'h0) begin n_fail++; $display("FAIL reset_vs_write got %h want 0", rdA); end
      n_checks++; if (pAny !== 1'b0 || pA !== 1'b0 || pB !== 1'b0) begin n_fail++; $display("FAIL reset_vs_reserve got %b%b%b want 000", pAny, pA, pB); end
      n_checks++; if (rdB !== 32'h0) begin n_fail++; $display("FAIL reset_clears_entries got %h want 0", rdB); end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         ctrl_reset_n     = ($urandom_range(0, 49) != 0);
         ctrl_writeEnable = $urandom_range(0, 1);
         ctrl_writeReg    = 5'($urandom_range(0, 31));
         ctrl_byteEnable  = 4'($urandom_range(0, 15));
         data_writeReg    = $urandom;
         ctrl_reserve     = ($urandom_range(0, 2) == 0);
         ctrl_reserveReg  = 5'($urandom_range(0, 31));
         ctrl_readRegA    = ($urandom_range(0, 3) == 0) ? ctrl_writeReg : 5'($urandom_range(0, 31));
         ctrl_readRegB    = ($urandom_range(0, 3) == 0) ? ctrl_readRegA : 5'($urandom_range(0, 31));
         #1;
         n_checks++; if (rdA !== exp_rd(ctrl_readRegA)) begin n_fail++; $display("FAIL rand_rdA i=%0d a=%0d got %h want %h", i, ctrl_readRegA, rdA, exp_rd(ctrl_readRegA)); end
         n_checks++; if (rdB !== exp_rd(ctrl_readRegB)) begin n_fail++; $display("FAIL rand_rdB i=%0d a=%0d got %h want %h", i, ctrl_readRegB, rdB, exp_rd(ctrl_readRegB)); end
         n_checks++; if (pA !== exp_pend(ctrl_readRegA) || pB !== exp_pend(ctrl_readRegB)) begin n_fail++; $display("FAIL rand_pend i=%0d got %b%b want %b%b", i, pA, pB, exp_pend(ctrl_readRegA), exp_pend(ctrl_readRegB)); end
         n_checks++; if (pAny !== exp_any() || rpAny !== exp_any()) begin n_fail++; $display("FAIL rand_pend_any i=%0d got %b/%b want %b", i, pAny, rpAny, exp_any()); end
         n_checks++; if (rpA !== m_pend[ctrl_readRegA]) begin n_fail++; $display("FAIL rand_rr_pendA i=%0d got %b want %b", i, rpA, m_pend[ctrl_readRegA]); end
         tick();
         n_checks++; if (rrA !== exp_rrA || rrB !== exp_rrB) begin n_fail++; $display("FAIL rand_rr i=%0d got %h/%h want %h/%h", i, rrA, rrB, exp_rrA, exp_rrB); end
      end
      idle(); ctrl_reset_n = 1;
   endtask

   initial begin
      for (int n = 0; n < 32; n++) begin m_mem[n] = '0; m_pend[n] = 1'b0; end
      exp_rrA = '0; exp_rrB = '0;
      test_reset();
      test_full_write();
      test_byte_enable();
      test_zero_reg();
      test_pending();
      test_bypass();
      test_reset_overrides();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
